// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that hands one requester's byte at a time to a shared UART
// transmitter, with a free-running baud tick and a registered IDLE/ISSUE/WAIT handshake.
module uart_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 868
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic [$clog2(N_REQ)-1:0]   grant_id,
  output logic                       busy,
  output logic                       enable_clk,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_done
);

  localparam int GW = $clog2(N_REQ);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t            state_reg, state_next;
  logic [CW-1:0]     baud_cnt_reg;
  logic              enable_reg;
  logic [N_REQ-1:0]  ready_reg, ready_next;
  logic [GW-1:0]     grant_reg, grant_next;
  logic [GW-1:0]     last_grant_reg, last_grant_next;
  logic [7:0]        data_reg, data_next;
  logic              valid_reg, valid_next;
  logic              busy_reg, busy_next;

  logic [GW-1:0]     cand [N_REQ];
  logic [GW-1:0]     winner;
  logic              any_req;

  // Free-running baud divider; the tick lands one cycle after the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      baud_cnt_reg <= '0;
      enable_reg   <= 1'b0;
    end else begin
      baud_cnt_reg <= (baud_cnt_reg == BAUD_LAST) ? '0 : baud_cnt_reg + 1'b1;
      enable_reg   <= (baud_cnt_reg == BAUD_LAST);
    end
  end

  // cand[k] is the requester examined k-th, starting just after the last winner.
  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cand
      assign cand[gi] = GW'((int'(last_grant_reg) + 1 + gi) % N_REQ);
    end
  endgenerate

  always_comb begin
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) winner = cand[k];
    end
  end

  assign any_req = |req_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= S_IDLE;
      ready_reg      <= '0;
      grant_reg      <= '0;
      last_grant_reg <= GW'(N_REQ - 1);
      data_reg       <= '0;
      valid_reg      <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      ready_reg      <= ready_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      data_reg       <= data_next;
      valid_reg      <= valid_next;
      busy_reg       <= busy_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (any_req)    state_next = S_ISSUE;
      S_ISSUE: if (enable_reg) state_next = S_WAIT;
      S_WAIT:  if (tx_done)    state_next = S_IDLE;
      default:                 state_next = S_IDLE;
    endcase
  end

  // Only IDLE samples the requesters, so anything they do while busy is ignored.
  always_comb begin
    ready_next      = '0;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    data_next       = data_reg;
    valid_next      = valid_reg;
    busy_next       = busy_reg;
    case (state_reg)
      S_IDLE: begin
        if (any_req) begin
          ready_next[winner] = 1'b1;
          grant_next         = winner;
          last_grant_next    = winner;
          data_next          = req_data[8*winner +: 8];
          valid_next         = 1'b1;
          busy_next          = 1'b1;
        end
      end
      S_ISSUE: if (enable_reg) valid_next = 1'b0;
      S_WAIT:  if (tx_done)    busy_next  = 1'b0;
      default: begin
        valid_next = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  assign req_ready  = ready_reg;
  assign grant_id   = grant_reg;
  assign busy       = busy_reg;
  assign enable_clk = enable_reg;
  assign tx_valid   = valid_reg;
  assign tx_data    = data_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: baud tick timing, round-robin order, table of
// grant transactions, spurious tx_done in ISSUE and reset while waiting.
module tb_uart_tx_arbiter;

  localparam int N   = 4;
  localparam int CPB = 4;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           busy;
  logic           enable_clk;
  logic           tx_valid;
  logic [7:0]     tx_data;
  logic           tx_done = 1'b0;

  int checks = 0;
  int passed = 0;

  uart_tx_arbiter #(.N_REQ(N), .CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .enable_clk (enable_clk),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_done    (tx_done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    int          exp_grant;
    logic [7:0]  exp_byte;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_ready();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        seen = 1'b1;
        break;
      end
    end
    check("ready_seen", {31'd0, seen}, 32'd1);
  endtask

  // Called at the grant negedge; runs the frame to tx_done and checks the handshake.
  task automatic finish_frame(input logic [7:0] exp_byte);
    bit   seen = 1'b0;
    logic prev_en = 1'b0;
    for (int i = 0; i < 4*CPB + 4; i++) begin
      if (i == 1) check("ready_one_cycle", {28'd0, req_ready}, 32'd0);
      if (!tx_valid) begin
        seen = 1'b1;
        break;
      end
      prev_en = enable_clk;
      @(negedge clk);
    end
    check("tx_valid_drop", {31'd0, seen}, 32'd1);
    check("drop_after_enable", {31'd0, prev_en}, 32'd1);
    check("busy_in_wait", {31'd0, busy}, 32'd1);
    check("tx_data_stable", {24'd0, tx_data}, {24'd0, exp_byte});
    tx_done = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("busy_released", {31'd0, busy}, 32'd0);
    check("no_grant_on_done", {28'd0, req_ready}, 32'd0);
  endtask

  task automatic check_grant(input int g, input logic [7:0] b);
    check("req_ready", {28'd0, req_ready}, 32'd1 << g);
    check("grant_id", {30'd0, grant_id}, g);
    check("tx_data", {24'd0, tx_data}, {24'd0, b});
    check("tx_valid_on_grant", {31'd0, tx_valid}, 32'd1);
    check("busy_on_grant", {31'd0, busy}, 32'd1);
    $display("grant: id=%0d data=0x%02h ready=%b", grant_id, tx_data, req_ready);
  endtask

  initial begin
    logic [31:0] fair_data;
    logic [7:0]  b;
    bit          aligned;

    vecs[0] = '{4'b0010, 32'h0000_A500, 1, 8'hA5};
    vecs[1] = '{4'b1111, 32'h4433_2211, 2, 8'h33};
    vecs[2] = '{4'b1100, 32'h9C8B_7A69, 3, 8'h9C};
    vecs[3] = '{4'b0101, 32'h0F1E_2D3C, 0, 8'h3C};
    vecs[4] = '{4'b1000, 32'hE400_0000, 3, 8'hE4};
    vecs[5] = '{4'b0001, 32'h0000_005A, 0, 8'h5A};
    vecs[6] = '{4'b0110, 32'h7766_5544, 1, 8'h55};
    vecs[7] = '{4'b0100, 32'h00C7_0000, 2, 8'hC7};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", {28'd0, req_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_enable", {31'd0, enable_clk}, 32'd0);
    check("rst_tx_data", {24'd0, tx_data}, 32'd0);
    check("rst_grant", {30'd0, grant_id}, 32'd0);

    // Baud tick: released at cycle 0, ticks at 4, 8, 12
    rst = 1'b0;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      check("baud_tick", {31'd0, enable_clk}, (n % 4 == 0) ? 32'd1 : 32'd0);
    end
    $display("baud: 14 cycles sampled after reset release");

    // Round-robin fairness with all requesters pending
    fair_data = 32'hD3C2_B1A0;
    req_data  = fair_data;
    req_valid = 4'b1111;
    for (int k = 0; k < 6; k++) begin
      wait_ready();
      b = fair_data[8*(k%4) +: 8];
      check_grant(k % 4, b);
      if (k == 5) req_valid = 4'b0000;
      finish_frame(b);
    end

    // Table of grant transactions
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      req_valid = vecs[v].valid;
      req_data  = vecs[v].data;
      wait_ready();
      check_grant(vecs[v].exp_grant, vecs[v].exp_byte);
      req_valid = 4'b0000;
      req_data  = 32'hFFFF_FFFF;
      finish_frame(vecs[v].exp_byte);
    end

    // Spurious tx_done while in ISSUE
    aligned = 1'b0;
    for (int i = 0; i < 2*CPB; i++) begin
      @(negedge clk);
      if (enable_clk) begin
        aligned = 1'b1;
        break;
      end
    end
    check("baud_align", {31'd0, aligned}, 32'd1);
    req_data  = 32'h1122_3344;
    req_valid = 4'b0001;
    @(negedge clk);
    check_grant(0, 8'h44);
    req_valid = 4'b0000;
    tx_done   = 1'b1;
    @(negedge clk);
    tx_done = 1'b0;
    check("spurious_busy", {31'd0, busy}, 32'd1);
    check("spurious_tx_valid", {31'd0, tx_valid}, 32'd1);
    finish_frame(8'h44);

    // Reset while in WAIT
    @(negedge clk);
    req_data  = 32'h5566_7788;
    req_valid = 4'b0100;
    wait_ready();
    check_grant(2, 8'h66);
    req_valid = 4'b0000;
    aligned = 1'b0;
    for (int i = 0; i < 4*CPB; i++) begin
      if (!tx_valid) begin
        aligned = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reached_wait", {31'd0, aligned}, 32'd1);
    req_valid = 4'b1111;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstwait_busy", {31'd0, busy}, 32'd0);
    check("rstwait_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rstwait_ready", {28'd0, req_ready}, 32'd0);
    check("rstwait_grant", {30'd0, grant_id}, 32'd0);
    wait_ready();
    check_grant(0, 8'h88);
    req_valid = 4'b0000;
    finish_frame(8'h88);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
